// File: rtl/ref_scheduler_if.sv
// Refresh scheduler bus: interval/duration config, sequencer
// handshake and status back to the command interface.
interface ref_scheduler_if #(
  parameter int RC_W   = 16,
  parameter int RD_W   = 4,
  parameter int PEND_W = 4
);
  logic              ref_en;
  logic              load_rfcnt;
  logic [RC_W-1:0]   refresh_count;
  logic [RD_W-1:0]   ref_dur;
  logic              ref_gnt;
  logic              ovf_clr;
  logic              ref_req;
  logic              ref_urgent;
  logic              ref_cmd;
  logic              ref_busy;
  logic [PEND_W-1:0] pend_cnt;
  logic              ref_overflow;

  modport master (
    output ref_en, load_rfcnt, refresh_count,
    output ref_dur, ref_gnt, ovf_clr,
    input  ref_req, ref_urgent, ref_cmd,
    input  ref_busy, pend_cnt, ref_overflow
  );

  modport slave (
    input  ref_en, load_rfcnt, refresh_count,
    input  ref_dur, ref_gnt, ovf_clr,
    output ref_req, ref_urgent, ref_cmd,
    output ref_busy, pend_cnt, ref_overflow
  );
endinterface

// File: rtl/ref_scheduler.sv
// SDRAM auto-refresh scheduler: interval ticks, postponed
// refresh queue and req/gnt driven refresh command sequencing.
module ref_scheduler #(
  parameter int RC_W     = 16,
  parameter int RD_W     = 4,
  parameter int PEND_MAX = 8,
  parameter int PEND_W   = 4,
  parameter int URG_TH   = 6
) (
  input logic            clk0,
  input logic            reset,
  ref_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_CMD,
    S_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [RC_W-1:0]   tmr_q, tmr_d;
  logic [RD_W-1:0]   wcnt_q, wcnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              reload_q;
  logic              ovf_q, ovf_d;
  logic              cmd_q;
  logic              run, tick, dec, full, ovf_set, pend_nz;

  assign run     = bus.ref_en && !reload_q;
  assign tick    = run && (tmr_q == RC_W'(1));
  assign dec     = (state_q == S_CMD);
  assign full    = (pend_q == PEND_W'(PEND_MAX));
  assign ovf_set = tick && !dec && full;
  assign pend_nz = (pend_q != '0);

  // tmr==0 also reloads so a zero timer after reset starts counting
  always_comb begin
    tmr_d = tmr_q - RC_W'(1);
    if (!run || tick || tmr_q == '0)
      tmr_d = bus.refresh_count;
  end

  always_comb begin
    pend_d = pend_q;
    if (state_q == S_IDLE && !bus.ref_en)
      pend_d = '0;
    else if (tick && !dec && !full)
      pend_d = pend_q + PEND_W'(1);
    else if (dec && !tick)
      pend_d = pend_q - PEND_W'(1);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set)
      ovf_d = 1'b1;
    else if (bus.ovf_clr)
      ovf_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ref_en && pend_nz)
          state_d = S_REQ;
      end
      S_REQ: begin
        if (!bus.ref_en)
          state_d = S_IDLE;
        else if (bus.ref_gnt)
          state_d = S_CMD;
      end
      S_CMD: begin
        wcnt_d  = bus.ref_dur;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q <= RD_W'(1))
          state_d = (bus.ref_en && pend_nz) ? S_REQ : S_IDLE;
        else
          wcnt_d = wcnt_q - RD_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      wcnt_q   <= '0;
      pend_q   <= '0;
      reload_q <= 1'b0;
      ovf_q    <= 1'b0;
      cmd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      wcnt_q   <= wcnt_d;
      pend_q   <= pend_d;
      reload_q <= bus.load_rfcnt;
      ovf_q    <= ovf_d;
      cmd_q    <= (state_d == S_CMD);
    end
  end

  assign bus.ref_req      = (state_q == S_REQ);
  assign bus.ref_busy     = (state_q == S_CMD) || (state_q == S_WAIT);
  assign bus.ref_cmd      = cmd_q;
  assign bus.pend_cnt     = pend_q;
  assign bus.ref_overflow = ovf_q;
  assign bus.ref_urgent   = (pend_q >= PEND_W'(URG_TH));

endmodule

// File: tb/tb_ref_scheduler.sv
// Directed bench for ref_scheduler: period, backlog, coincidence,
// reload, disable and async reset scenarios.
module tb_ref_scheduler;

  logic clk0 = 1'b0;
  logic reset = 1'b1;

  ref_scheduler_if #(.RC_W(16), .RD_W(4), .PEND_W(4)) bus ();

  ref_scheduler #(
    .RC_W(16), .RD_W(4), .PEND_MAX(8), .PEND_W(4), .URG_TH(6)
  ) dut (
    .clk0 (clk0),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk0 = ~clk0;

  int errs = 0;
  int checks = 0;
  int n_req, n_cmd, n_busy;
  int f_pend, f_cmd, f_urg, f_ovf, gap, last;
  int pend_h [64];

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  function automatic int outs();
    return int'({bus.ref_req, bus.ref_urgent, bus.ref_cmd,
                 bus.ref_busy, bus.ref_overflow, bus.pend_cnt});
  endfunction

  task automatic do_reset(input int rc, input int rd, input logic g);
    reset = 1'b1;
    bus.ref_en = 1'b0;
    bus.load_rfcnt = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.refresh_count = 16'(rc);
    bus.ref_dur = 4'(rd);
    bus.ref_gnt = g;
    step();
    step();
    reset = 1'b0;
    step();
    step();
  endtask

  task automatic run_win(input int n);
    n_req = 0; n_cmd = 0; n_busy = 0;
    f_pend = -1; f_cmd = -1; f_urg = -1; f_ovf = -1;
    gap = -1; last = -1;
    for (int i = 0; i < n; i++) begin
      step();
      bus.load_rfcnt = 1'b0;
      if (bus.ref_req) n_req++;
      if (bus.ref_busy) n_busy++;
      if (bus.ref_cmd) begin
        n_cmd++;
        if (f_cmd < 0) f_cmd = i;
        if (last >= 0) gap = i - last;
        last = i;
      end
      if (f_pend < 0 && bus.pend_cnt != 0) f_pend = i;
      if (f_urg < 0 && bus.ref_urgent) f_urg = i;
      if (f_ovf < 0 && bus.ref_overflow) f_ovf = i;
      if (i < 64) pend_h[i] = int'(bus.pend_cnt);
    end
  endtask

  initial begin
    // basic period
    do_reset(10, 3, 1'b1);
    chk("rst_outs", outs(), 0);
    bus.ref_en = 1'b1;
    run_win(28);
    chk("p_first_tick", f_pend, 9);
    chk("p_first_cmd", f_cmd, 11);
    chk("p_period", gap, 10);
    chk("p_n_cmd", n_cmd, 2);
    chk("p_n_busy", n_busy, 8);
    chk("p_n_req", n_req, 2);
    chk("p_pend_end", int'(bus.pend_cnt), 0);

    // backlog, saturation and drain
    do_reset(2, 3, 1'b0);
    bus.ref_en = 1'b1;
    run_win(20);
    chk("b_first_tick", f_pend, 1);
    chk("b_first_urg", f_urg, 11);
    chk("b_first_ovf", f_ovf, 17);
    chk("b_pend_sat", int'(bus.pend_cnt), 8);
    chk("b_req_hold", int'(bus.ref_req), 1);
    bus.ref_gnt = 1'b1;
    bus.refresh_count = 16'd0;
    bus.load_rfcnt = 1'b1;
    run_win(40);
    chk("b_first_cmd", f_cmd, 0);
    chk("b_n_cmd", n_cmd, 8);
    chk("b_n_busy", n_busy, 32);
    chk("b_n_req", n_req, 7);
    chk("b_pend_end", int'(bus.pend_cnt), 0);
    chk("b_ovf_sticky", int'(bus.ref_overflow), 1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    chk("b_ovf_clr", int'(bus.ref_overflow), 0);

    // tick coincident with command
    do_reset(1, 0, 1'b1);
    bus.ref_en = 1'b1;
    run_win(8);
    chk("c_pend_cmd0", pend_h[2], 3);
    chk("c_pend_after0", pend_h[3], 3);
    chk("c_pend_cmd1", pend_h[5], 5);
    chk("c_pend_after1", pend_h[6], 5);
    chk("c_n_cmd", n_cmd, 2);
    chk("c_n_busy", n_busy, 4);

    // interval reload
    do_reset(100, 3, 1'b1);
    bus.ref_en = 1'b1;
    run_win(30);
    chk("r_no_tick", f_pend, -1);
    bus.refresh_count = 16'd5;
    bus.load_rfcnt = 1'b1;
    run_win(7);
    chk("r_tick_after_load", f_pend, 6);
    bus.refresh_count = 16'd0;
    bus.load_rfcnt = 1'b1;
    run_win(40);
    chk("r_drain_cmd", n_cmd, 1);
    chk("r_drain_pend", int'(bus.pend_cnt), 0);
    run_win(20);
    chk("r_zero_req", n_req, 0);

    // disable in WAIT and in REQ
    do_reset(3, 3, 1'b1);
    bus.ref_en = 1'b1;
    run_win(6);
    chk("d_first_cmd", f_cmd, 4);
    chk("d_in_wait", int'(bus.ref_busy), 1);
    chk("d_pend_wait", int'(bus.pend_cnt), 1);
    bus.ref_en = 1'b0;
    run_win(4);
    chk("d_busy_done", n_busy, 2);
    chk("d_no_cmd", n_cmd, 0);
    chk("d_pend_idle", pend_h[2], 1);
    chk("d_pend_clr", int'(bus.pend_cnt), 0);
    bus.ref_en = 1'b1;
    run_win(3);
    chk("d_tmr_reload", f_pend, 2);
    step();
    chk("d_req", int'(bus.ref_req), 1);
    bus.ref_en = 1'b0;
    step();
    chk("d_req_drop", int'(bus.ref_req), 0);
    chk("d_req_nocmd", int'(bus.ref_cmd), 0);
    step();
    chk("d_req_pclr", int'(bus.pend_cnt), 0);

    // async reset during WAIT
    do_reset(10, 3, 1'b1);
    bus.ref_en = 1'b1;
    run_win(13);
    chk("a_in_wait", int'(bus.ref_busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("a_outs", outs(), 0);
    step();
    #2;
    reset = 1'b0;
    run_win(14);
    chk("a_first_tick", f_pend, 10);
    chk("a_first_cmd", f_cmd, 12);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
